usb_fs_rx_phy: RTL and testbench



---
 rtl/usb_fs_rx_phy_pkg.sv | 27 ++
 rtl/usb_fs_rx_phy_input_sync.sv | 37 +++
 rtl/usb_fs_rx_phy.sv | 220 ++++++++++++++++++++++
 tb/tb_usb_fs_rx_phy.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_rx_phy_pkg.sv
// Shared line encodings, sync pattern, PID values and receiver state type
// for the full-speed USB receive front end and its bench.
package usb_fs_rx_phy_pkg;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // Decoded sync bits packed first-bit-in-[0]: seven zeros then a one.
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_WAIT_EOP
  } rx_state_e;

endpackage

// File: rtl/usb_fs_rx_phy_input_sync.sv
// Two-flop synchronizer for the raw D+/D- pins plus a strobe marking every
// change of the synchronized D+ level.
module usb_input_sync (
  input  logic clock48,
  input  logic reset_n,
  input  logic usb_dp,
  input  logic usb_dn,
  output logic dp_sync,
  output logic dn_sync,
  output logic dp_edge
);

  logic dp_p0, dp_p1, dp_p2;
  logic dn_p0, dn_p1;

  // Reset to the idle J level so no spurious edge appears on release.
  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      dp_p0 <= 1'b1;
      dp_p1 <= 1'b1;
      dp_p2 <= 1'b1;
      dn_p0 <= 1'b0;
      dn_p1 <= 1'b0;
    end else begin
      dp_p0 <= usb_dp;
      dp_p1 <= dp_p0;
      dp_p2 <= dp_p1;
      dn_p0 <= usb_dn;
      dn_p1 <= dn_p0;
    end
  end

  assign dp_sync = dp_p1;
  assign dn_sync = dn_p1;
  assign dp_edge = dp_p1 ^ dp_p2;

endmodule

// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive PHY: 4x oversampled clock recovery, sync detect,
// NRZI decode, bit unstuffing, byte assembly, EOP and bus-reset detection.
module usb_fs_rx_phy #(
  parameter int CLOCKS_PER_BIT   = 4,
  parameter int SAMPLE_PHASE     = 2,
  parameter int RESET_SE0_CYCLES = 120
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       usb_dp,
  input  logic       usb_dn,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_error,
  output logic [1:0] line_state,
  output logic       bus_reset
);
  import usb_fs_rx_phy_pkg::*;

  localparam int PH_W  = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int SE0_W = $clog2(RESET_SE0_CYCLES + 1);

  logic dp_s, dn_s, dp_edge;

  usb_input_sync u_input_sync (
    .clock48 (clock48),
    .reset_n (reset_n),
    .usb_dp  (usb_dp),
    .usb_dn  (usb_dn),
    .dp_sync (dp_s),
    .dn_sync (dn_s),
    .dp_edge (dp_edge)
  );

  assign line_state = {dp_s, dn_s};

  logic is_se0, is_j, is_k;
  assign is_se0 = (line_state == LINE_SE0);
  assign is_j   = (line_state == LINE_J);
  assign is_k   = (line_state == LINE_K);

  // Bit clock recovery: the cycle an edge is seen counts as phase 0.
  logic [PH_W-1:0] phase_q, phase_cur;
  logic            sample;
  assign phase_cur = dp_edge ? '0 : phase_q;
  assign sample    = (phase_cur == PH_W'(SAMPLE_PHASE));

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n)
      phase_q <= '0;
    else if (phase_cur == PH_W'(CLOCKS_PER_BIT - 1))
      phase_q <= '0;
    else
      phase_q <= phase_cur + 1'b1;
  end

  // SE0 duration counter runs regardless of packet state.
  logic [SE0_W-1:0] se0_cnt_q;
  logic             bus_reset_q;

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      se0_cnt_q   <= '0;
      bus_reset_q <= 1'b0;
    end else begin
      if (!is_se0)
        se0_cnt_q <= '0;
      else if (se0_cnt_q != SE0_W'(RESET_SE0_CYCLES))
        se0_cnt_q <= se0_cnt_q + 1'b1;
      bus_reset_q <= is_se0 && (se0_cnt_q >= SE0_W'(RESET_SE0_CYCLES - 1));
    end
  end

  rx_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_q, ones_d;
  logic [7:0] shift_q, shift_d, shift_in;
  logic       prev_dp_q, prev_dp_d;
  logic       se0_seen_q, se0_seen_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_active_q, rx_active_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_eop_q, rx_eop_d;
  logic       rx_error_q, rx_error_d;
  logic       dec_bit;

  assign dec_bit  = (dp_s == prev_dp_q);
  assign shift_in = {dec_bit, shift_q[7:1]};

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      shift_q     <= '0;
      prev_dp_q   <= 1'b1;
      se0_seen_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_active_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_eop_q    <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      prev_dp_q   <= prev_dp_d;
      se0_seen_q  <= se0_seen_d;
      rx_data_q   <= rx_data_d;
      rx_active_q <= rx_active_d;
      rx_valid_q  <= rx_valid_d;
      rx_eop_q    <= rx_eop_d;
      rx_error_q  <= rx_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    prev_dp_d   = prev_dp_q;
    se0_seen_d  = se0_seen_q;
    rx_data_d   = rx_data_q;
    rx_active_d = rx_active_q & ~rx_eop_q;
    rx_valid_d  = 1'b0;
    rx_eop_d    = 1'b0;
    rx_error_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dp_edge && is_k) begin
          state_d   = ST_SYNC;
          shift_d   = '0;
          bit_cnt_d = '0;
          prev_dp_d = 1'b1;
        end
      end
      ST_SYNC: begin
        if (sample) begin
          if (is_se0) begin
            state_d = ST_IDLE;
          end else begin
            shift_d   = shift_in;
            prev_dp_d = dp_s;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_in == SYNC_PATTERN) begin
                state_d     = ST_DATA;
                rx_active_d = 1'b1;
                ones_d      = 3'd1;
                bit_cnt_d   = '0;
              end else begin
                state_d    = ST_WAIT_EOP;
                se0_seen_d = 1'b0;
              end
            end
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          if (is_se0) begin
            rx_eop_d   = 1'b1;
            rx_error_d = (bit_cnt_q != 3'd0);
            state_d    = ST_WAIT_EOP;
            se0_seen_d = 1'b1;
          end else begin
            prev_dp_d = dp_s;
            // After six ones the next bit must be a stuffed zero.
            if (ones_q == 3'd6) begin
              if (!dec_bit) begin
                ones_d = '0;
              end else begin
                rx_error_d  = 1'b1;
                rx_active_d = 1'b0;
                state_d     = ST_WAIT_EOP;
                se0_seen_d  = 1'b0;
              end
            end else begin
              shift_d   = shift_in;
              ones_d    = dec_bit ? ones_q + 1'b1 : 3'd0;
              bit_cnt_d = bit_cnt_q + 1'b1;
              if (bit_cnt_q == 3'd7) begin
                rx_valid_d = 1'b1;
                rx_data_d  = shift_in;
              end
            end
          end
        end
      end
      ST_WAIT_EOP: begin
        if (sample) begin
          if (is_se0)
            se0_seen_d = 1'b1;
          else if (is_j && se0_seen_q)
            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus_reset_q) begin
      state_d     = ST_IDLE;
      rx_active_d = 1'b0;
      rx_valid_d  = 1'b0;
      rx_eop_d    = 1'b0;
      rx_error_d  = 1'b0;
    end
  end

  assign rx_active = rx_active_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_eop    = rx_eop_q;
  assign rx_error  = rx_error_q;
  assign bus_reset = bus_reset_q;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Bench for usb_fs_rx_phy: encodes packets into line symbols (stuffing, NRZI)
// and checks received events against an ordered expectation queue.
`timescale 1ns/1ps
module tb_usb_fs_rx_phy;
  import usb_fs_rx_phy_pkg::*;

  logic       clock48 = 1'b0;
  logic       reset_n = 1'b0;
  logic       usb_dp  = 1'b1;
  logic       usb_dn  = 1'b0;
  logic       rx_active, rx_valid, rx_eop, rx_error, bus_reset;
  logic [7:0] rx_data;
  logic [1:0] line_state;

  always #10.417 clock48 = ~clock48;

  usb_fs_rx_phy dut (
    .clock48    (clock48),
    .reset_n    (reset_n),
    .usb_dp     (usb_dp),
    .usb_dn     (usb_dn),
    .rx_active  (rx_active),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_eop     (rx_eop),
    .rx_error   (rx_error),
    .line_state (line_state),
    .bus_reset  (bus_reset)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock48) cyc <= cyc + 1;

  // Expected events in order: kind 0 = byte, 1 = EOP (val = error flag), 2 = stuff error.
  int         exp_kind[$];
  logic [7:0] exp_val[$];

  logic [1:0] sym_q[$];
  logic [1:0] lvl;
  int         ones;
  int         n_stuff;
  int         last_syms;
  logic [7:0] pkt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock48);
    #1;
  endtask

  task automatic pop_exp(output int kind, output logic [7:0] val);
    if (exp_kind.size() == 0) begin
      kind = -1;
      val  = 8'h00;
    end else begin
      kind = exp_kind.pop_front();
      val  = exp_val.pop_front();
    end
  endtask

  // Encoder: a 0 toggles the line, a 1 holds it; a zero is stuffed after six ones.
  task automatic push_raw(input logic b);
    if (!b) lvl = (lvl == LINE_J) ? LINE_K : LINE_J;
    sym_q.push_back(lvl);
  endtask

  task automatic push_bit(input logic b, input logic stuff_en);
    push_raw(b);
    ones = b ? ones + 1 : 0;
    if (stuff_en && ones == 6) begin
      push_raw(1'b0);
      ones = 0;
      n_stuff++;
    end
  endtask

  task automatic begin_packet(input logic [7:0] sync_bits);
    lvl     = LINE_J;
    ones    = 0;
    n_stuff = 0;
    for (int i = 0; i < 8; i++) push_bit(sync_bits[i], 1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic expect_it);
    for (int i = 0; i < 8; i++) push_bit(b[i], 1'b1);
    if (expect_it) begin
      exp_kind.push_back(0);
      exp_val.push_back(b);
    end
  endtask

  task automatic end_packet(input logic expect_eop, input logic err);
    sym_q.push_back(LINE_SE0);
    sym_q.push_back(LINE_SE0);
    for (int i = 0; i < 6; i++) sym_q.push_back(LINE_J);
    if (expect_eop) begin
      exp_kind.push_back(1);
      exp_val.push_back({7'd0, err});
    end
  endtask

  task automatic drive(input realtime per, input int limit);
    last_syms = sym_q.size();
    for (int i = 0; i < sym_q.size() && i < limit; i++) begin
      {usb_dp, usb_dn} = sym_q[i];
      #(per);
    end
    sym_q.delete();
  endtask

  task automatic settle(input string name);
    repeat (12) tick();
    check({name, "_drained"}, exp_kind.size(), 0);
  endtask

  task automatic send_pkt(input string name, input realtime per);
    begin_packet(SYNC_PATTERN);
    foreach (pkt[i]) push_byte(pkt[i], 1'b1);
    end_packet(1'b1, 1'b0);
    drive(per, 100000);
    settle(name);
  endtask

  // Compare process: every received event is matched against the expectation queue.
  initial begin
    int         kind;
    logic [7:0] val;
    int         last_valid_cyc;
    logic       eop_prev;
    last_valid_cyc = -100;
    eop_prev       = 1'b0;
    forever begin
      tick();
      if (reset_n) begin
        if (eop_prev) check("active_drop_after_eop", rx_active, 1'b0);
        eop_prev = rx_eop;
        if (rx_valid) begin
          check("active_with_valid", rx_active, 1'b1);
          check("valid_not_with_eop", rx_eop, 1'b0);
          pop_exp(kind, val);
          check("event_is_byte", kind, 0);
          check("byte_value", rx_data, val);
          last_valid_cyc = cyc;
        end
        if (rx_eop) begin
          check("valid_to_eop_gap_ok", (cyc - last_valid_cyc) >= 2, 1'b1);
          pop_exp(kind, val);
          check("event_is_eop", kind, 1);
          check("eop_error_flag", rx_error, val[0]);
        end else if (rx_error) begin
          pop_exp(kind, val);
          check("event_is_stuff_error", kind, 2);
          check("active_low_on_abort", rx_active, 1'b0);
        end
      end else begin
        eop_prev = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, time %0t, required under 2 ms", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, n;

    // Reset values
    repeat (3) @(posedge clock48);
    #1;
    check("rst_line_state", line_state, LINE_J);
    check("rst_rx_active", rx_active, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_eop", rx_eop, 1'b0);
    check("rst_rx_error", rx_error, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_bus_reset", bus_reset, 1'b0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Long SE0: bus_reset timing and input latency
    {usb_dp, usb_dn} = LINE_SE0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (line_state == LINE_SE0) break;
    end
    check("sync_latency", n, 2);
    t0 = cyc;
    for (int i = 0; i < 300; i++) begin
      if (bus_reset) break;
      tick();
    end
    t1 = cyc;
    check("bus_reset_rise", t1 - t0, 120);
    repeat (150) tick();
    check("bus_reset_hold", bus_reset, 1'b1);
    check("bus_reset_no_active", rx_active, 1'b0);
    {usb_dp, usb_dn} = LINE_J;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (line_state == LINE_J) break;
    end
    t2 = cyc;
    for (int i = 0; i < 20; i++) begin
      if (!bus_reset) break;
      tick();
    end
    t3 = cyc;
    check("bus_reset_fall", t3 - t2, 1);
    repeat (10) tick();

    // ACK handshake
    pkt = '{PID_ACK};
    send_pkt("ack", 83.333);
    check("ack_symbol_count", last_syms, 24);
    check("ack_rx_data_held", rx_data, 8'hD2);
    check("ack_idle_inactive", rx_active, 1'b0);

    // SETUP token then DATA0 with GET_DESCRIPTOR and its CRC16
    pkt = '{PID_SETUP, 8'h01, 8'h00};
    send_pkt("setup", 83.333);
    pkt = '{PID_DATA0, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send_pkt("data0", 83.333);
    check("data0_last_byte", rx_data, 8'h94);

    // Stuff-heavy payload
    pkt = '{8'hFF, 8'hFF, 8'h3F};
    send_pkt("stuffing", 83.333);
    check("stuff_bits_inserted", n_stuff, 3);

    // Stuff error: unstuffed run of ones, then a clean ACK
    begin_packet(SYNC_PATTERN);
    for (int i = 0; i < 8; i++) push_bit(1'b1, 1'b0);
    exp_kind.push_back(2);
    exp_val.push_back(8'h00);
    end_packet(1'b0, 1'b0);
    drive(83.333, 100000);
    settle("stuff_err");
    check("stuff_err_inactive", rx_active, 1'b0);
    pkt = '{PID_ACK};
    send_pkt("ack_after_err", 83.333);

    // EOP after 12 data bits
    begin_packet(SYNC_PATTERN);
    push_byte(8'hA5, 1'b1);
    push_bit(1'b1, 1'b1);
    push_bit(1'b0, 1'b1);
    push_bit(1'b1, 1'b1);
    push_bit(1'b1, 1'b1);
    end_packet(1'b1, 1'b1);
    drive(83.333, 100000);
    settle("partial_byte");

    // Corrupted sync: ignored completely
    begin_packet(8'hC0);
    push_byte(8'h12, 1'b0);
    end_packet(1'b0, 1'b0);
    drive(83.333, 100000);
    settle("bad_sync");

    // Bit period tolerance
    pkt = '{PID_DATA1, 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'hFE, 8'h3C};
    send_pkt("fast_81ns", 81.0);
    send_pkt("slow_86ns", 86.0);

    // Reset in the middle of a packet
    begin_packet(SYNC_PATTERN);
    push_byte(PID_NAK, 1'b0);
    push_byte(8'h33, 1'b0);
    drive(83.333, 14);
    check("midpkt_active", rx_active, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midpkt_rst_active", rx_active, 1'b0);
    check("midpkt_rst_data", rx_data, 8'h00);
    {usb_dp, usb_dn} = LINE_J;
    repeat (4) @(posedge clock48);
    #3;
    reset_n = 1'b1;
    settle("post_reset_quiet");
    pkt = '{PID_ACK};
    send_pkt("ack_after_reset", 83.333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
